// File: rtl/fsm_run_sched_pkg.sv
// Shared types and defaults for the run/done scheduler: FSM states, job result,
// and the default requester count and WAIT timeout.
package fsm_run_sched_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OK  = 1'b0,
        ERR = 1'b1
    } result_t;

endpackage

// File: rtl/fsm_run_sched_rr_pick.sv
// Combinational round-robin picker: searches req starting one past last_grant
// and returns a one-hot grant plus a flag saying any request was present.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic          valid
);

    // Offset i=1 is the highest-priority slot; the grantee itself comes last.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 1; i <= N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!valid && (j == (int'(last_grant) + i) % N) && req[j]) begin
                    grant[j] = 1'b1;
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fsm_run_sched.sv
// Shares one run/done engine among N_REQ requesters: round-robin grant, one run
// pulse per job, bounded wait for done, then an ack or err pulse to the grantee.
module fsm_run_sched
    import fsm_run_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_grant,
    output logic [N_REQ-1:0] o_ack,
    output logic [N_REQ-1:0] o_err,
    output logic             o_run,
    input  logic             i_done,
    output logic             o_busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state, state_d;
    result_t          result_q, result_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    grant_idx;
    logic [N_REQ-1:0] pick_grant;
    logic             pick_valid;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req        (i_req),
        .last_grant (last_q),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) grant_idx = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            result_q <= OK;
            cnt      <= '0;
            grant_q  <= '0;
            last_q   <= IW'(N_REQ - 1);
        end else begin
            state    <= state_d;
            result_q <= result_d;
            cnt      <= cnt_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state;
        result_d = result_q;
        cnt_d    = cnt;
        grant_d  = grant_q;
        last_d   = last_q;
        unique case (state)
            IDLE: begin
                grant_d = pick_valid ? pick_grant : '0;
                if (pick_valid) state_d = RUN;
            end
            RUN: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done arriving on the last allowed cycle still counts as success.
                if (i_done) begin
                    result_d = OK;
                    state_d  = DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    result_d = ERR;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DONE: begin
                last_d  = grant_idx;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_grant = grant_q;
    assign o_run   = (state == RUN);
    assign o_busy  = (state != IDLE);
    assign o_ack   = (state == DONE && result_q == OK)  ? grant_q : '0;
    assign o_err   = (state == DONE && result_q == ERR) ? grant_q : '0;

endmodule

// File: tb/tb_fsm_run_sched.sv
// Scoreboard bench for fsm_run_sched: the driver predicts each job's grantee,
// result and latency from round-robin arithmetic; a monitor checks what the DUT shows.
module tb_fsm_run_sched;

    localparam int N  = 4;
    localparam int TO = 16;

    typedef struct {
        logic [N-1:0] grant;
        bit           ok;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [N-1:0] i_req = '0;
    logic         i_done = 1'b0;
    logic [N-1:0] o_grant, o_ack, o_err;
    logic         o_run, o_busy;

    exp_t         exp_q[$];
    exp_t         e;
    int           n_cmp = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           run_cyc = 0;
    int           job_delay = 0;
    bit           stray = 1'b0;
    logic [N-1:0] cur_req = '0;
    int           m_last = N - 1;

    fsm_run_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (i_req),
        .o_grant (o_grant),
        .o_ack   (o_ack),
        .o_err   (o_err),
        .o_run   (o_run),
        .i_done  (i_done),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    // Monitor: invariants every cycle, grant on each run pulse, result on each ack/err.
    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            n_cmp++;
            if (!$onehot0(o_grant) || !$onehot0(o_ack) || !$onehot0(o_err) ||
                (o_ack & o_err) != '0 || o_busy != (o_grant != '0)) begin
                n_fail++;
                $display("FAIL invariant: grant=%b ack=%b err=%b busy=%b", o_grant, o_ack, o_err, o_busy);
            end
            if (o_run) begin
                run_cyc = cyc;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL run_grant: got grant=%b, expected no job", o_grant);
                end else if (o_grant !== exp_q[0].grant) begin
                    n_fail++;
                    $display("FAIL run_grant: got %b, expected %b", o_grant, exp_q[0].grant);
                end
            end
            if (o_ack != '0 || o_err != '0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL result: got ack=%b err=%b, expected no pulse", o_ack, o_err);
                end else begin
                    e = exp_q.pop_front();
                    if (!(e.ok ? (o_ack === e.grant && o_err == '0) : (o_err === e.grant && o_ack == '0)) ||
                        (cyc - run_cyc) != e.lat) begin
                        n_fail++;
                        $display("FAIL result: got ack=%b err=%b lat=%0d, expected %s=%b lat=%0d",
                                 o_ack, o_err, cyc - run_cyc, e.ok ? "ack" : "err", e.grant, e.lat);
                    end
                end
            end
        end
    end

    // Engine model: done arrives job_delay WAIT cycles after the first one, or never.
    initial begin
        forever begin
            @(negedge clk);
            if (o_run && reset_n) begin
                if (job_delay <= TO) begin
                    repeat (job_delay + 1) @(negedge clk);
                    i_done = 1'b1;
                    @(negedge clk);
                    i_done = 1'b0;
                end
            end else if (stray) begin
                i_done = 1'b1;
                @(negedge clk);
                i_done = 1'b0;
                stray = 1'b0;
            end
        end
    end

    function automatic int rr_next(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic abort_run(input string what);
        n_fail++;
        $display("FAIL %s: bound expired", what);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    // One job: add requests, predict, then optionally raise/drop requests mid-job.
    task automatic job(input logic [N-1:0] add, input int d,
                       input logic [N-1:0] raise, input logic [N-1:0] drop);
        int   idx;
        bit   got;
        exp_t x;
        cur_req = cur_req | add;
        idx = rr_next(cur_req, m_last);
        x.grant = '0;
        x.grant[idx] = 1'b1;
        x.ok  = (d < TO);
        x.lat = (d < TO) ? d + 2 : TO + 1;
        exp_q.push_back(x);
        job_delay = d;
        i_req = cur_req;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            got = o_run;
        end
        if (!got) abort_run("wait_run");
        cur_req = (cur_req | raise) & ~drop;
        i_req = cur_req;
        got = 1'b0;
        for (int k = 0; k < TO + 6 && !got; k++) begin
            @(negedge clk);
            got = (o_ack != '0 || o_err != '0);
        end
        if (!got) abort_run("wait_result");
        cur_req = cur_req & ~x.grant;
        i_req = cur_req;
        m_last = idx;
    endtask

    task automatic drain();
        while (cur_req != '0) job('0, $urandom_range(0, TO - 1), '0, '0);
    endtask

    initial begin
        logic [N-1:0] add;
        #1 reset_n = 1'b0;
        #2;
        n_cmp++;
        if ({o_grant, o_ack, o_err, o_run, o_busy} != '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b, expected 0", {o_grant, o_ack, o_err, o_run, o_busy});
        end
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fairness with all four requesting, starting from requester 0.
        for (int i = 0; i < 5; i++) job('1, $urandom_range(0, TO - 1), '0, '0);
        drain();
        // Single request with done two cycles after run.
        job(4'b0001, 1, '0, '0);
        // Timeout with no done, then done on the last allowed cycle, then one too late.
        job(4'b0100, 255, '0, '0);
        job(4'b0010, TO - 1, '0, '0);
        job(4'b0010, TO, '0, '0);
        // Request raised during a job waits for the next round; minimum latency.
        job(4'b0001, 5, 4'b0010, '0);
        job('0, 0, '0, '0);
        // Grantee drops its request mid-job and still gets its pulse.
        job(4'b1000, 4, '0, 4'b1000);
        // Stray done while idle.
        stray = 1'b1;
        repeat (4) @(negedge clk);

        for (int t = 0; t < 60; t++) begin
            if (cur_req == '0) begin
                if ($urandom_range(0, 1) == 1) begin
                    stray = 1'b1;
                    repeat ($urandom_range(2, 5)) @(negedge clk);
                end
                add = N'($urandom_range(1, (1 << N) - 1));
            end else begin
                add = N'($urandom_range(0, (1 << N) - 1));
            end
            job(add, $urandom_range(0, TO + 3),
                ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0,
                ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0);
        end
        drain();

        // Reset in the middle of WAIT aborts the job silently.
        job_delay = 255;
        cur_req = 4'b0100;
        e.grant = '0;
        e.grant[rr_next(cur_req, m_last)] = 1'b1;
        e.ok = 1'b0;
        e.lat = TO + 1;
        exp_q.push_back(e);
        i_req = cur_req;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_grant, o_ack, o_err, o_run, o_busy} != '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got %b, expected 0", {o_grant, o_ack, o_err, o_run, o_busy});
        end
        exp_q.delete();
        cur_req = '0;
        i_req = '0;
        m_last = N - 1;
        #9 reset_n = 1'b1;
        repeat (TO + 4) @(negedge clk);
        job(4'b1001, 3, '0, '0);
        drain();

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
